// File: rtl/key_evt_pkg.sv
// Shared types for the front-panel key event scheduler.
package key_evt_pkg;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'd0,
        EVT_LONG    = 2'd1,
        EVT_REPEAT  = 2'd2,
        EVT_RELEASE = 2'd3
    } evt_type_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HELD     = 2'd1,
        REPEAT   = 2'd2,
        LONGHELD = 2'd3
    } key_state_t;

    // Index width that never collapses to zero bits for a single key.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_evt_fsm.sv
// One key's edge detector, hold/repeat counters and event FSM.
// The emit/type outputs are combinational so the pending slot is written on
// the same edge that sees the key edge or the qualifying tick.
// Build option: KEY_EVT_REPEAT_EN enables REPEAT events after LONG; without it
// the key parks in LONGHELD until release and the repeat counter is not built.
module key_evt_fsm
    import key_evt_pkg::*;
#(
    parameter int LONG_TICKS   = 500,
    parameter int REPEAT_TICKS = 100
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      key_level_i,
    input  logic      tick_i,
    output logic      emit_o,
    output evt_type_t type_o
);

    localparam int HW = $clog2(LONG_TICKS + 1);

    key_state_t      state_q, state_d;
    logic            prev_q;
    logic [HW-1:0]   hold_q, hold_d, hold_inc;
    logic            rise, fall;

`ifdef KEY_EVT_REPEAT_EN
    localparam int RW = $clog2(REPEAT_TICKS + 1);
    logic [RW-1:0]   rep_q, rep_d, rep_inc;
`endif

    // Next-state and event decision; a fall always wins over a tick event.
    always_comb begin
        rise     = key_level_i & ~prev_q;
        fall     = ~key_level_i & prev_q;
        state_d  = state_q;
        hold_d   = hold_q;
        hold_inc = hold_q + 1'b1;
        emit_o   = 1'b0;
        type_o   = EVT_PRESS;
`ifdef KEY_EVT_REPEAT_EN
        rep_d    = rep_q;
        rep_inc  = rep_q + 1'b1;
`endif
        case (state_q)
            IDLE: begin
                if (rise) begin
                    emit_o  = 1'b1;
                    type_o  = EVT_PRESS;
                    hold_d  = '0;
                    state_d = HELD;
                end
            end
            HELD: begin
                if (fall) begin
                    emit_o  = 1'b1;
                    type_o  = EVT_RELEASE;
                    state_d = IDLE;
                end else if (tick_i && hold_q != HW'(LONG_TICKS)) begin
                    hold_d = hold_inc;
                    if (hold_inc == HW'(LONG_TICKS)) begin
                        emit_o = 1'b1;
                        type_o = EVT_LONG;
`ifdef KEY_EVT_REPEAT_EN
                        rep_d   = '0;
                        state_d = REPEAT;
`else
                        state_d = LONGHELD;
`endif
                    end
                end
            end
`ifdef KEY_EVT_REPEAT_EN
            REPEAT: begin
                if (fall) begin
                    emit_o  = 1'b1;
                    type_o  = EVT_RELEASE;
                    state_d = IDLE;
                end else if (tick_i && rep_q != RW'(REPEAT_TICKS)) begin
                    if (rep_inc == RW'(REPEAT_TICKS)) begin
                        emit_o = 1'b1;
                        type_o = EVT_REPEAT;
                        rep_d  = '0;
                    end else begin
                        rep_d  = rep_inc;
                    end
                end
            end
`else
            LONGHELD: begin
                if (fall) begin
                    emit_o  = 1'b1;
                    type_o  = EVT_RELEASE;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State, key history and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prev_q  <= 1'b0;
            hold_q  <= '0;
`ifdef KEY_EVT_REPEAT_EN
            rep_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            prev_q  <= key_level_i;
            hold_q  <= hold_d;
`ifdef KEY_EVT_REPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end

endmodule

// File: rtl/key_evt_ctrl.sv
// Key event scheduler: per-key FSMs feed one pending slot each; a round-robin
// arbiter drains the slots into a single valid/ready output register.
// Build option: KEY_EVT_REPEAT_EN (passed through to key_evt_fsm).
module key_evt_ctrl
    import key_evt_pkg::*;
#(
    parameter int N_KEYS       = 4,
    parameter int TICK_DIV     = 50000,
    parameter int LONG_TICKS   = 500,
    parameter int REPEAT_TICKS = 100
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_KEYS-1:0]             key_level,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [idx_w(N_KEYS)-1:0]      evt_key,
    output logic [1:0]                    evt_type,
    output logic                          ovf,
    input  logic                          ovf_clr
);

    localparam int KW = idx_w(N_KEYS);
    localparam int PW = idx_w(TICK_DIV);

    logic [PW-1:0]     pre_q;
    logic              tick;
    logic [N_KEYS-1:0] emit;
    evt_type_t         emit_typ [N_KEYS];

    logic [N_KEYS-1:0] slot_vld_q, slot_vld_d, grant;
    evt_type_t         slot_typ_q [N_KEYS];
    evt_type_t         slot_typ_d [N_KEYS];
    logic              drop;

    logic [KW-1:0]     rr_q, win, evt_key_q;
    logic              found, load, evt_valid_q, ovf_q;
    evt_type_t         evt_type_q;
    int                idx;

    assign tick = (pre_q == PW'(TICK_DIV - 1));

    // Free-running hold-timing prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    pre_q <= '0;
        else if (tick) pre_q <= '0;
        else           pre_q <= pre_q + 1'b1;
    end

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        key_evt_fsm #(
            .LONG_TICKS  (LONG_TICKS),
            .REPEAT_TICKS(REPEAT_TICKS)
        ) u_fsm (
            .clk        (clk),
            .rst_n      (rst_n),
            .key_level_i(key_level[g]),
            .tick_i     (tick),
            .emit_o     (emit[g]),
            .type_o     (emit_typ[g])
        );
    end

    assign load = !evt_valid_q || evt_ready;

    // Round-robin search: first valid slot at or above rr_q, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        grant = '0;
        for (int o = 0; o < N_KEYS; o++) begin
            idx = (int'(rr_q) + o) % N_KEYS;
            if (!found && slot_vld_q[idx]) begin
                found = 1'b1;
                win   = KW'(idx);
            end
        end
        if (load && found) grant[win] = 1'b1;
    end

    // Slot update: a grant frees the slot before a new emit may fill it.
    always_comb begin
        drop       = 1'b0;
        slot_vld_d = slot_vld_q & ~grant;
        for (int i = 0; i < N_KEYS; i++) begin
            slot_typ_d[i] = slot_typ_q[i];
            if (emit[i]) begin
                if (slot_vld_d[i]) begin
                    drop = 1'b1;
                end else begin
                    slot_vld_d[i] = 1'b1;
                    slot_typ_d[i] = emit_typ[i];
                end
            end
        end
    end

    // Pending slots, output register, rr pointer and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_vld_q  <= '0;
            for (int i = 0; i < N_KEYS; i++) slot_typ_q[i] <= EVT_PRESS;
            rr_q        <= '0;
            evt_valid_q <= 1'b0;
            evt_key_q   <= '0;
            evt_type_q  <= EVT_PRESS;
            ovf_q       <= 1'b0;
        end else begin
            slot_vld_q <= slot_vld_d;
            for (int i = 0; i < N_KEYS; i++) slot_typ_q[i] <= slot_typ_d[i];
            if (load) begin
                evt_valid_q <= found;
                if (found) begin
                    evt_key_q  <= win;
                    evt_type_q <= slot_typ_q[win];
                    rr_q       <= (win == KW'(N_KEYS - 1)) ? '0 : win + 1'b1;
                end
            end
            if (drop)         ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_key   = evt_key_q;
    assign evt_type  = evt_type_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_key_evt_ctrl.sv
// Scoreboard bench for key_evt_ctrl: stimulus pushes expected events, a
// negedge monitor pops and compares every accepted event.
module tb_key_evt_ctrl;

    localparam int EP = 0, EL = 1, ER = 2, EX = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key_level;
    logic       evt_valid, evt_ready, ovf, ovf_clr;
    logic [1:0] evt_key, evt_type;

    int n_chk  = 0;
    int n_pass = 0;
    int ecnt;
    int q[$];

    always #5 clk = ~clk;

    key_evt_ctrl #(
        .N_KEYS(4), .TICK_DIV(4), .LONG_TICKS(3), .REPEAT_TICKS(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_level(key_level),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_key(evt_key), .evt_type(evt_type),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    // Edges since reset release; a tick lands on edges where ecnt becomes 0 mod 4.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    function automatic int ev(input int k, input int t);
        return k * 4 + t;
    endfunction

    // Monitor: every handshake must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            if (q.size() == 0) chk("unexpected_evt", ev(int'(evt_key), int'(evt_type)), -1);
            else               chk("evt", ev(int'(evt_key), int'(evt_type)), q.pop_front());
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Return just after an edge with ecnt == 0 mod 4, so the next edge is 1 mod 4.
    task automatic align();
        do step(1); while (ecnt % 4 != 0);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 80) begin step(1); n++; end
        step(3);
        chk(name, q.size(), 0);
    endtask

    task automatic tap(input int k, input int cyc);
        q.push_back(ev(k, EP));
        q.push_back(ev(k, EX));
        key_level[k] = 1'b1;
        step(cyc);
        key_level[k] = 1'b0;
        drain("tap_drain");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; key_level = '0; evt_ready = 1'b1; ovf_clr = 1'b0;
        step(2);
        @(negedge clk);
        chk("rst_valid", evt_valid, 0);
        chk("rst_key", evt_key, 0);
        chk("rst_type", evt_type, 0);
        chk("rst_ovf", ovf, 0);
        #2 rst_n = 1'b1;
        step(2);

        // Single tap on key 1.
        tap(1, 5);
        @(negedge clk);
        chk("tap_ovf", ovf, 0);

        // Long hold on key 2: press at edge p (1 mod 4), ticks at p+3,+7,+11 (LONG),
        // +15,+19 (REPEAT),+23,+27 (REPEAT),+31,+35 (REPEAT),+39; fall at p+40.
        align();
        q.push_back(ev(2, EP));
        q.push_back(ev(2, EL));
`ifdef KEY_EVT_REPEAT_EN
        repeat (3) q.push_back(ev(2, ER));
`endif
        q.push_back(ev(2, EX));
        key_level[2] = 1'b1;
        step(40);
        key_level[2] = 1'b0;
        drain("long_drain");

        // Tap key 3 so rr wraps to 0.
        tap(3, 4);

        // Round robin from rr=0: 0,1,3 then releases 0,1,3.
        foreach (q[i]) q.delete(i);
        q.push_back(ev(0, EP)); q.push_back(ev(1, EP)); q.push_back(ev(3, EP));
        q.push_back(ev(0, EX)); q.push_back(ev(1, EX)); q.push_back(ev(3, EX));
        key_level = 4'b1011;
        step(5);
        key_level = 4'b0000;
        drain("rr0_drain");

        // Tap key 1 so rr=2, then expect 3,0,1.
        tap(1, 4);
        q.push_back(ev(3, EP)); q.push_back(ev(0, EP)); q.push_back(ev(1, EP));
        q.push_back(ev(3, EX)); q.push_back(ev(0, EX)); q.push_back(ev(1, EX));
        key_level = 4'b1011;
        step(5);
        key_level = 4'b0000;
        drain("rr2_drain");

        // Backpressure: two taps on key 0 with evt_ready low.
        evt_ready = 1'b0;
        key_level[0] = 1'b1; step(3);
        @(negedge clk);
        chk("bp_valid", evt_valid, 1);
        chk("bp_evt", ev(int'(evt_key), int'(evt_type)), ev(0, EP));
        chk("bp_ovf_pre", ovf, 0);
        key_level[0] = 1'b0; step(3);
        key_level[0] = 1'b1; step(3);
        key_level[0] = 1'b0; step(3);
        @(negedge clk);
        chk("bp_valid_hold", evt_valid, 1);
        chk("bp_evt_hold", ev(int'(evt_key), int'(evt_type)), ev(0, EP));
        chk("bp_ovf_set", ovf, 1);
        step(1);
        ovf_clr = 1'b1; step(1); ovf_clr = 1'b0;
        @(negedge clk);
        chk("bp_ovf_clr", ovf, 0);
        q.push_back(ev(0, EP));
        q.push_back(ev(0, EX));
        evt_ready = 1'b1;
        drain("bp_drain");

        // Async reset while key 2 is past LONG and PRESS is stuck on the output.
        evt_ready = 1'b0;
        align();
        key_level[2] = 1'b1;
        step(21);
        @(negedge clk);
        chk("ar_valid_pre", evt_valid, 1);
        chk("ar_evt_pre", ev(int'(evt_key), int'(evt_type)), ev(2, EP));
`ifdef KEY_EVT_REPEAT_EN
        chk("ar_ovf_pre", ovf, 1);
`endif
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", evt_valid, 0);
        chk("ar_key", evt_key, 0);
        chk("ar_type", evt_type, 0);
        chk("ar_ovf", ovf, 0);
        step(1);
        q.push_back(ev(2, EP));
        evt_ready = 1'b1;
        #2 rst_n = 1'b1;
        step(6);
        chk("ar_one_press", q.size(), 0);
        q.push_back(ev(2, EX));
        key_level[2] = 1'b0;
        drain("ar_drain");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/key_evt_ctrl.md
Name: key_evt_ctrl

Overview:
- Event scheduler for the front-panel keys of the timer.
- Takes N debounced, clk-synchronous, active-high key levels from the per-key debouncers.
- Classifies each key's activity into PRESS / LONG / REPEAT / RELEASE events.
- Arbitrates all keys round-robin into one event stream with a valid/ready handshake for the timer control FSM.

Parameters:
- N_KEYS, 4, number of key inputs (1..16).
- TICK_DIV, 50000, clk cycles per hold-timing tick (1 ms at 50 MHz).
- LONG_TICKS, 500, ticks a key must stay held after PRESS before LONG fires (>=1).
- REPEAT_TICKS, 100, ticks between successive REPEAT events after LONG (>=1).

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset, asynchronous assert, active-low.
- key_level  in  N_KEYS  debounced key states, 1 = pressed, already synchronous to clk.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts the event when evt_valid && evt_ready at a clk edge.
- evt_key  out  $clog2(N_KEYS) (min 1)  index of the key that caused the event.
- evt_type  out  2  event code: 0 PRESS, 1 LONG, 2 REPEAT, 3 RELEASE.
- ovf  out  1  sticky flag: an event was dropped.
- ovf_clr  in  1  synchronous clear of ovf.

Behaviour:
- Reset (async, rst_n=0):
  - evt_valid=0, evt_key=0, evt_type=0, ovf=0.
  - All key FSMs go to IDLE; all pending slots empty; prescaler=0; rr pointer=0; key_prev=0.
- Tick prescaler:
  - Counts 0..TICK_DIV-1 continuously.
  - tick=1 on the cycle the count equals TICK_DIV-1.
- Edge detection per key i: rise = key_level[i] & ~key_prev[i]; fall = ~key_level[i] & key_prev[i].
- Per-key FSM (one instance per key):
  - IDLE: on rise, emit PRESS, hold_cnt=0, go to HELD.
  - HELD: on tick, hold_cnt++. When a tick brings hold_cnt to LONG_TICKS, emit LONG, rep_cnt=0, go to REPEAT.
  - REPEAT: on tick, rep_cnt++. When rep_cnt reaches REPEAT_TICKS, emit REPEAT and set rep_cnt=0.
  - HELD/REPEAT: on fall, emit RELEASE, go to IDLE. Fall has priority over a tick-driven LONG/REPEAT in the same cycle; only RELEASE is emitted.
  - Counters saturate; they never wrap.
- Pending slots:
  - One slot per key, holding a valid bit and a type.
  - An FSM emit writes the slot at that clk edge.
  - If the slot is still valid and not being granted in the same cycle, the new event is dropped and ovf is set.
  - If the slot is granted in the same cycle, the new event is stored. Grant frees before write.
- Arbitration and output register:
  - The output register loads when !evt_valid || evt_ready.
  - Winner is the first valid slot searching from rr pointer upward with wrap.
  - On load: evt_valid=1, evt_key/evt_type = winner; that slot is cleared; rr pointer = winner+1 mod N_KEYS.
  - No valid slot on a load cycle: evt_valid goes 0.
  - evt_key/evt_type are stable while evt_valid && !evt_ready.
- Latency: rise at edge k writes the slot at edge k; evt_valid is high after edge k+1 if the output is free. Back-to-back accept gives 1 event per cycle.
- ovf:
  - Set on any drop.
  - ovf_clr clears it. A drop in the same cycle as ovf_clr leaves ovf=1.
- Reset mid-operation: all state discarded; a key still held after reset is seen as a rise, giving a fresh PRESS.

Optional Feature:
- Macro: KEY_EVT_REPEAT_EN.
- Defined: REPEAT state and REPEAT events as above.
- Undefined:
  - After LONG, the FSM enters a LONGHELD state that emits nothing until fall, then RELEASE.
  - rep_cnt logic is not built.
  - evt_type value 2 never appears.

Decomposition:
- Shared package key_evt_pkg:
  - evt_type_t enum (EVT_PRESS=0, EVT_LONG=1, EVT_REPEAT=2, EVT_RELEASE=3).
  - key_state_t enum (IDLE, HELD, REPEAT, LONGHELD).
- Sub-module key_evt_fsm: one key's edge detect, hold/repeat counters and FSM.
  - Outputs emit + type.
  - Instantiated N_KEYS times by a generate loop.
- The prescaler, pending slots, round-robin arbiter and output register stay in key_evt_ctrl.

Test Plan:
All scenarios use TICK_DIV=4, LONG_TICKS=3, REPEAT_TICKS=2, N_KEYS=4, KEY_EVT_REPEAT_EN defined unless noted.
- Single tap: key 1 high 5 cycles, evt_ready=1 -> PRESS(key 1) then RELEASE(key 1); no LONG; ovf=0.
- Long hold: key 2 held 40 cycles -> PRESS; LONG at 3rd tick after press; REPEAT every 2 ticks; RELEASE after fall.
- Same sweep without KEY_EVT_REPEAT_EN -> PRESS, LONG, RELEASE only.
- Round-robin: keys 0, 1, 3 rise in the same cycle with rr=0 and evt_ready=1 -> events on keys 0, 1, 3 on consecutive cycles. Repeating with rr=2 -> order 3, 0, 1.
- Backpressure/overflow: evt_ready=0, key 0 taps twice -> first PRESS held stable on the outputs; RELEASE fills the slot; second PRESS dropped; ovf=1. ovf_clr pulse -> ovf=0.
- Async reset: rst_n low mid-REPEAT while evt_valid=1 -> outputs 0 immediately. Key still held at release of reset -> exactly one fresh PRESS.
